gps_ubx_rx: RTL and testbench

Receive path for the ZED-F9P GPS UART link. Deserialises the asynchronous `gps_rx` line, frames UBX protocol packets and verifies their Fletcher checksum. Streams payload bytes and frame status to the tag's capture logic. It is the receive counterpart of the GPS transmit path and sits inside the GPS subsystem on the 100 MHz main clock.

---
 rtl/gps_ubx_rx.sv | 337 +++++++++++++++++++++++++++++++++
 tb/tb_gps_ubx_rx.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gps_ubx_rx.sv
// ---------------------------------------------------------------------------
// gps_ubx_rx
//   Receive path for the ZED-F9P UART link. Deserialises the asynchronous
//   gps_rx line (8N1, LSB first), frames UBX packets and verifies their
//   Fletcher checksum. Payload bytes and frame status are streamed as
//   one-cycle strobes; there is no backpressure.
//
// Parameters
//   CLK_HZ   main clock frequency in Hz
//   BAUD     UART bit rate; CLKS_PER_BIT = CLK_HZ / BAUD (truncated)
//   MAX_LEN  largest accepted UBX payload length in bytes
//
// Ports
//   clk          main clock
//   n_reset      synchronous, active-low reset
//   gps_rx       asynchronous UART line from the GPS, idles high
//   msg_class    class byte of the current or last header
//   msg_id       ID byte of the current or last header
//   msg_len      payload length of the current or last header
//   pay_data     payload byte, valid while pay_valid is high
//   pay_valid    one-cycle strobe per payload byte
//   frame_done   one-cycle strobe after the CK_B byte
//   frame_ok     checksum result, qualified by frame_done, held until next
//   err_framing  one-cycle strobe when a stop bit is sampled low
//   err_len      one-cycle strobe when a header length exceeds MAX_LEN
// ---------------------------------------------------------------------------
module gps_ubx_rx #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int BAUD    = 38400,
  parameter int MAX_LEN = 1024
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        gps_rx,
  output logic [7:0]  msg_class,
  output logic [7:0]  msg_id,
  output logic [15:0] msg_len,
  output logic [7:0]  pay_data,
  output logic        pay_valid,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        err_framing,
  output logic        err_len
);

  localparam int                CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int                CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0]  BIT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST    = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0]       MAX_LEN_W    = 17'(MAX_LEN);

  localparam logic [7:0] SYNC_CHAR_1 = 8'hB5;
  localparam logic [7:0] SYNC_CHAR_2 = 8'h62;

  // -------------------------------------------------------------------------
  // Input synchroniser. Both stages and the edge-detect history reset high so
  // an idle line never looks like a start edge after reset.
  // -------------------------------------------------------------------------
  logic rx_meta;
  logic rx_sync;
  logic rx_prev;

  // NOTE: sequential state is only ever assigned with <=, so every flop
  // samples the pre-edge value of its neighbours regardless of block order.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= gps_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // -------------------------------------------------------------------------
  // UART receiver
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP
  } uart_state_t;

  uart_state_t      u_state;
  uart_state_t      u_next;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             stop_hold;   // low stop bit seen, waiting for line high
  logic             sample;      // mid-bit sample point of the current state
  logic             byte_stb;    // good stop bit: shift holds a complete byte
  logic             frm_err_stb; // stop bit sampled low

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      u_state <= U_IDLE;
    end else begin
      u_state <= u_next;
    end
  end

  // Start bit is re-checked half a bit in; later bits are a whole bit apart,
  // which keeps every sample at the centre of its bit.
  // NOTE: every signal driven from always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    sample = 1'b0;
    case (u_state)
      U_START: sample = (clk_cnt == HALF_LAST);
      U_DATA,
      U_STOP:  sample = (clk_cnt == BIT_LAST);
      default: sample = 1'b0;
    endcase
  end

  always_comb begin
    u_next = u_state;
    case (u_state)
      U_IDLE: begin
        if (rx_prev && !rx_sync) u_next = U_START;
      end
      U_START: begin
        // High at mid-start is a glitch: drop it without producing a byte.
        if (sample) u_next = rx_sync ? U_IDLE : U_DATA;
      end
      U_DATA: begin
        if (sample && bit_cnt == 3'd7) u_next = U_STOP;
      end
      U_STOP: begin
        if (stop_hold) begin
          if (rx_sync) u_next = U_IDLE;
        end else if (sample && rx_sync) begin
          u_next = U_IDLE;
        end
      end
      default: u_next = U_IDLE;
    endcase
  end

  always_comb begin
    byte_stb    = 1'b0;
    frm_err_stb = 1'b0;
    if (u_state == U_STOP && !stop_hold && sample) begin
      byte_stb    = rx_sync;
      frm_err_stb = !rx_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      stop_hold <= 1'b0;
    end else begin
      // The bit timer restarts on every state change and every sample point.
      if (u_next != u_state || sample) begin
        clk_cnt <= '0;
      end else begin
        clk_cnt <= clk_cnt + CNT_W'(1);
      end

      if (u_state == U_START) begin
        bit_cnt <= '0;
      end else if (u_state == U_DATA && sample) begin
        shift   <= {rx_sync, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (u_state != U_STOP) begin
        stop_hold <= 1'b0;
      end else if (frm_err_stb) begin
        stop_hold <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // UBX parser. Advances on byte_stb; the received byte is in shift.
  // -------------------------------------------------------------------------
  typedef enum logic [3:0] {
    P_SYNC1,
    P_SYNC2,
    P_CLASS,
    P_ID,
    P_LEN_L,
    P_LEN_H,
    P_PAYLOAD,
    P_CK_A,
    P_CK_B
  } parser_state_t;

  parser_state_t p_state;
  parser_state_t p_next;
  logic [7:0]    len_lo;
  logic [15:0]   len_full;
  logic          len_over;
  logic [15:0]   pay_cnt;
  logic [7:0]    ck_a;
  logic [7:0]    ck_b;
  logic [7:0]    ck_a_sum;
  logic [7:0]    ck_b_sum;
  logic [7:0]    rx_ck_a;

  logic          pay_stb_d;
  logic          done_stb_d;
  logic          ok_d;
  logic          elen_stb_d;

  assign len_full = {shift, len_lo};
  assign len_over = ({1'b0, len_full} > MAX_LEN_W);
  assign ck_a_sum = ck_a + shift;
  assign ck_b_sum = ck_b + ck_a_sum;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      p_state <= P_SYNC1;
    end else begin
      p_state <= p_next;
    end
  end

  always_comb begin
    p_next = p_state;
    if (frm_err_stb) begin
      // A corrupted byte anywhere inside a frame abandons that frame.
      p_next = P_SYNC1;
    end else if (byte_stb) begin
      case (p_state)
        P_SYNC1: begin
          if (shift == SYNC_CHAR_1) p_next = P_SYNC2;
        end
        P_SYNC2: begin
          if (shift == SYNC_CHAR_2)      p_next = P_CLASS;
          else if (shift == SYNC_CHAR_1) p_next = P_SYNC2;
          else                           p_next = P_SYNC1;
        end
        P_CLASS: p_next = P_ID;
        P_ID:    p_next = P_LEN_L;
        P_LEN_L: p_next = P_LEN_H;
        P_LEN_H: begin
          if (len_full == 16'd0) p_next = P_CK_A;
          else if (len_over)     p_next = P_SYNC1;
          else                   p_next = P_PAYLOAD;
        end
        P_PAYLOAD: begin
          if (pay_cnt + 16'd1 == msg_len) p_next = P_CK_A;
        end
        P_CK_A:  p_next = P_CK_B;
        P_CK_B:  p_next = P_SYNC1;
        default: p_next = P_SYNC1;
      endcase
    end
  end

  // Strobe values for the next cycle; registered below so every strobe
  // lands exactly one cycle after the stop-bit sample.
  always_comb begin
    pay_stb_d  = byte_stb && (p_state == P_PAYLOAD);
    done_stb_d = byte_stb && (p_state == P_CK_B);
    elen_stb_d = byte_stb && (p_state == P_LEN_H) && len_over;
    ok_d       = (rx_ck_a == ck_a) && (shift == ck_b);
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      msg_class   <= '0;
      msg_id      <= '0;
      msg_len     <= '0;
      pay_data    <= '0;
      pay_valid   <= 1'b0;
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
      err_framing <= 1'b0;
      err_len     <= 1'b0;
      len_lo      <= '0;
      pay_cnt     <= '0;
      ck_a        <= '0;
      ck_b        <= '0;
      rx_ck_a     <= '0;
    end else begin
      pay_valid   <= pay_stb_d;
      frame_done  <= done_stb_d;
      err_len     <= elen_stb_d;
      err_framing <= frm_err_stb;

      if (pay_stb_d)  pay_data <= shift;
      if (done_stb_d) frame_ok <= ok_d;

      if (byte_stb) begin
        case (p_state)
          P_SYNC2: begin
            if (shift == SYNC_CHAR_2) begin
              ck_a <= '0;
              ck_b <= '0;
            end
          end
          P_CLASS: begin
            msg_class <= shift;
            ck_a      <= ck_a_sum;
            ck_b      <= ck_b_sum;
          end
          P_ID: begin
            msg_id <= shift;
            ck_a   <= ck_a_sum;
            ck_b   <= ck_b_sum;
          end
          P_LEN_L: begin
            len_lo <= shift;
            ck_a   <= ck_a_sum;
            ck_b   <= ck_b_sum;
          end
          P_LEN_H: begin
            // Latched even when oversize so the offending length is visible.
            msg_len <= len_full;
            pay_cnt <= '0;
            ck_a    <= ck_a_sum;
            ck_b    <= ck_b_sum;
          end
          P_PAYLOAD: begin
            pay_cnt <= pay_cnt + 16'd1;
            ck_a    <= ck_a_sum;
            ck_b    <= ck_b_sum;
          end
          P_CK_A: begin
            rx_ck_a <= shift;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gps_ubx_rx.sv
// ---------------------------------------------------------------------------
// tb_gps_ubx_rx
//   Directed bench for gps_ubx_rx. A UART driver serialises byte sequences;
//   the expected strobe stream (payload bytes, frame results, errors) is
//   built from frame contents with plain checksum arithmetic and checked in
//   order by a monitor on every strobe cycle. The baud rate is raised so the
//   whole run stays short; the glitch pulse is scaled to the bit time.
// ---------------------------------------------------------------------------
module tb_gps_ubx_rx;

  localparam int CLK_HZ  = 100_000_000;
  localparam int BAUD    = 3_125_000;
  localparam int CPB     = CLK_HZ / BAUD;
  localparam int MAX_LEN = 1024;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        gps_rx;
  logic [7:0]  msg_class;
  logic [7:0]  msg_id;
  logic [15:0] msg_len;
  logic [7:0]  pay_data;
  logic        pay_valid;
  logic        frame_done;
  logic        frame_ok;
  logic        err_framing;
  logic        err_len;

  always #5 clk = ~clk;

  gps_ubx_rx #(
    .CLK_HZ  (CLK_HZ),
    .BAUD    (BAUD),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .gps_rx      (gps_rx),
    .msg_class   (msg_class),
    .msg_id      (msg_id),
    .msg_len     (msg_len),
    .pay_data    (pay_data),
    .pay_valid   (pay_valid),
    .frame_done  (frame_done),
    .frame_ok    (frame_ok),
    .err_framing (err_framing),
    .err_len     (err_len)
  );

  typedef enum logic [1:0] {EV_PAY, EV_DONE, EV_ELEN, EV_EFRM} ev_kind_t;

  typedef struct {
    ev_kind_t    kind;
    logic [7:0]  data;
    logic        ok;
    logic [7:0]  cls;
    logic [7:0]  id;
    logic [15:0] len;
  } ev_t;

  ev_t  exp_q[$];
  int   n_checks   = 0;
  int   n_errors   = 0;
  int   strobe_cnt = 0;
  logic mon_en     = 1'b0;
  logic in_stop    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input ev_kind_t k, input logic [7:0] d, input logic ok,
                         input logic [7:0] cls, input logic [7:0] id, input logic [15:0] len);
    ev_t e;
    e.kind = k;
    e.data = d;
    e.ok   = ok;
    e.cls  = cls;
    e.id   = id;
    e.len  = len;
    exp_q.push_back(e);
  endtask

  // Fletcher-8 pair over the first n bytes: {ck_a, ck_b}.
  function automatic logic [15:0] ck_of(input logic [7:0] d [20], input int n);
    int a = 0;
    int b = 0;
    for (int i = 0; i < n; i++) begin
      a = (a + int'(d[i])) % 256;
      b = (b + a) % 256;
    end
    return {a[7:0], b[7:0]};
  endfunction

  // Monitor: every strobe must be the next expected event, alone, and fall
  // inside the stop bit of the byte that caused it.
  always @(negedge clk) begin : monitor
    int          n;
    logic [31:0] kind_obs;
    ev_t         e;
    if (mon_en) begin
      n = int'(pay_valid) + int'(frame_done) + int'(err_len) + int'(err_framing);
      if (n > 1) check("strobe_exclusive", 32'(n), 32'd1);
      if (n != 0) begin
        strobe_cnt++;
        kind_obs = pay_valid ? 32'd0 : frame_done ? 32'd1 : err_len ? 32'd2 : 32'd3;
        check("strobe_in_stop_bit", 32'(in_stop), 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_strobe_kind", kind_obs, 32'hFF);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind", kind_obs, 32'(e.kind));
          case (e.kind)
            EV_PAY:  check("pay_data", 32'(pay_data), 32'(e.data));
            EV_DONE: begin
              check("frame_ok", 32'(frame_ok), 32'(e.ok));
              check("done_msg_class", 32'(msg_class), 32'(e.cls));
              check("done_msg_id", 32'(msg_id), 32'(e.id));
              check("done_msg_len", 32'(msg_len), 32'(e.len));
            end
            EV_ELEN: check("elen_msg_len", 32'(msg_len), 32'(e.len));
            default: ;
          endcase
        end
      end
    end
  end

  task automatic drive_bit(input logic v);
    gps_rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    in_stop = 1'b1;
    drive_bit(stop_ok);
    in_stop = 1'b0;
    if (!stop_ok) drive_bit(1'b1);
  endtask

  task automatic expect_drained(input string tag);
    check({tag, "_pending_events"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Sends B5 62 cls id len payload ck_a ck_b; ckb_xor corrupts CK_B.
  task automatic send_frame(input string tag, input logic [7:0] cls, input logic [7:0] id,
                            input logic [7:0] pay [16], input int n, input logic [7:0] ckb_xor);
    logic [7:0]  body [20];
    logic [15:0] ck;
    logic [15:0] len;
    body = '{default: 8'h00};
    len  = 16'(n);
    body[0] = cls;
    body[1] = id;
    body[2] = len[7:0];
    body[3] = len[15:8];
    for (int i = 0; i < n; i++) body[4 + i] = pay[i];
    ck = ck_of(body, n + 4);
    for (int i = 0; i < n; i++) push_ev(EV_PAY, pay[i], 1'b0, 8'h00, 8'h00, 16'h0000);
    push_ev(EV_DONE, 8'h00, (ckb_xor == 8'h00), cls, id, len);
    send_byte(8'hB5, 1'b1);
    send_byte(8'h62, 1'b1);
    for (int i = 0; i < n + 4; i++) send_byte(body[i], 1'b1);
    send_byte(ck[15:8], 1'b1);
    send_byte(ck[7:0] ^ ckb_xor, 1'b1);
    expect_drained(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_msg_class"}, 32'(msg_class), 32'd0);
    check({tag, "_msg_id"}, 32'(msg_id), 32'd0);
    check({tag, "_msg_len"}, 32'(msg_len), 32'd0);
    check({tag, "_pay_data"}, 32'(pay_data), 32'd0);
    check({tag, "_pay_valid"}, 32'(pay_valid), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_frame_ok"}, 32'(frame_ok), 32'd0);
    check({tag, "_err_framing"}, 32'(err_framing), 32'd0);
    check({tag, "_err_len"}, 32'(err_len), 32'd0);
  endtask

  initial begin : stim
    logic [7:0] pay [16];
    logic [7:0] vec [20];
    logic [7:0] fo;
    int         sc;

    n_reset = 1'b0;
    gps_rx  = 1'b1;
    repeat (4) @(negedge clk);
    check_all_zero("reset");
    n_reset = 1'b1;
    mon_en  = 1'b1;
    repeat (2 * CPB) @(negedge clk);

    // Pin the checksum model against hand-computed values.
    vec = '{default: 8'h00};
    vec[0] = 8'h05; vec[1] = 8'h01; vec[2] = 8'h02; vec[3] = 8'h00;
    vec[4] = 8'h06; vec[5] = 8'h01;
    check("ck_model_good_frame", 32'(ck_of(vec, 6)), 32'h0F38);
    vec = '{default: 8'h00};
    vec[0] = 8'h01; vec[1] = 8'h02;
    check("ck_model_len0_frame", 32'(ck_of(vec, 4)), 32'h030A);

    // Good frame: B5 62 05 01 02 00 06 01 0F 38.
    pay = '{default: 8'h00};
    pay[0] = 8'h06;
    pay[1] = 8'h01;
    send_frame("good", 8'h05, 8'h01, pay, 2, 8'h00);
    check("good_msg_class", 32'(msg_class), 32'h05);
    check("good_msg_id", 32'(msg_id), 32'h01);
    check("good_msg_len", 32'(msg_len), 32'd2);
    check("good_frame_ok_held", 32'(frame_ok), 32'd1);

    // Bad checksum: CK_B = 39.
    send_frame("bad_ck", 8'h05, 8'h01, pay, 2, 8'h01);
    check("bad_frame_ok_held", 32'(frame_ok), 32'd0);

    // Framing error on the first payload byte, then resync via B5 B5 62.
    push_ev(EV_EFRM, 8'h00, 1'b0, 8'h00, 8'h00, 16'h0000);
    send_byte(8'hB5, 1'b1);
    send_byte(8'h62, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h06, 1'b0);
    expect_drained("framing");
    check("framing_msg_len_hold", 32'(msg_len), 32'd2);
    send_byte(8'hB5, 1'b1);
    send_frame("resync", 8'h05, 8'h01, pay, 2, 8'h00);
    check("resync_frame_ok", 32'(frame_ok), 32'd1);

    // Glitch shorter than half a bit on an idle line.
    sc = strobe_cnt;
    gps_rx = 1'b0;
    repeat (CPB / 2 - 2) @(negedge clk);
    gps_rx = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    check("glitch_no_strobes", 32'(strobe_cnt - sc), 32'd0);

    // Oversize length 1025, then stray bytes that must not produce payload.
    push_ev(EV_ELEN, 8'h00, 1'b0, 8'h0A, 8'h04, 16'h0401);
    send_byte(8'hB5, 1'b1);
    send_byte(8'h62, 1'b1);
    send_byte(8'h0A, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    expect_drained("oversize");
    check("oversize_msg_class", 32'(msg_class), 32'h0A);
    check("oversize_msg_id", 32'(msg_id), 32'h04);
    check("oversize_msg_len", 32'(msg_len), 32'd1025);

    // Zero-length frame goes straight to the checksum bytes.
    send_frame("len0", 8'h01, 8'h02, pay, 0, 8'h00);
    check("len0_frame_ok", 32'(frame_ok), 32'd1);
    check("len0_msg_len", 32'(msg_len), 32'd0);

    // Reset in the middle of the second payload byte (0xF0), during bit 5.
    push_ev(EV_PAY, 8'h06, 1'b0, 8'h00, 8'h00, 16'h0000);
    send_byte(8'hB5, 1'b1);
    send_byte(8'h62, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h06, 1'b1);
    fo = 8'hF0;
    drive_bit(1'b0);
    for (int i = 0; i < 5; i++) drive_bit(fo[i]);
    gps_rx = 1'b1;
    repeat (8) @(negedge clk);
    n_reset = 1'b0;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    check_all_zero("reset_mid");
    repeat (CPB - 10) @(negedge clk);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    send_byte(8'hFE, 1'b1);
    send_byte(8'h27, 1'b1);
    expect_drained("reset_mid_rest");
    check("reset_mid_msg_class_cleared", 32'(msg_class), 32'd0);

    pay = '{default: 8'h00};
    pay[0] = 8'hAA;
    pay[1] = 8'h55;
    pay[2] = 8'h00;
    send_frame("after_reset", 8'h01, 8'h07, pay, 3, 8'h00);
    check("after_reset_frame_ok", 32'(frame_ok), 32'd1);
    check("after_reset_msg_len", 32'(msg_len), 32'd3);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
